// File: rtl/display_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : display_share_arbiter
//  Description : Shares the 4-digit seven-segment display between NREQ
//                requesters. The grant rotates round-robin. A new owner keeps
//                the display for at least HOLD_CYCLES cycles before another
//                requester can preempt it. The owner's 16-bit word is
//                registered onto disps, which feeds the digit-scan mux.
//
//  Parameters  : NREQ        - number of requesters (2..8)
//                HOLD_CYCLES - minimum ownership cycles before preemption (>=1)
//                IDLE_VALUE  - disps value while nobody owns the display
//
//  Ports       : clk       in   system clock, posedge
//                rst       in   synchronous active-high reset
//                req       in   [NREQ]     request per requester (level)
//                req_data  in   [16*NREQ]  word of requester i at [16*i+15:16*i]
//                grant     out  [NREQ]     one-hot owner, zero when idle
//                owner     out  [clog2]    owner index, zero when idle
//                busy      out  1 while an owner exists
//                disps     out  [16]       word for the display multiplexer
//
//  Build macro : HOLD_LAST_EN - when defined, disps keeps the last owner's word
//                in IDLE. IDLE_VALUE is then used only at reset.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module display_share_arbiter #(
    parameter int          NREQ        = 4,
    parameter int          HOLD_CYCLES = 1000,
    parameter logic [15:0] IDLE_VALUE  = 16'h0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [16*NREQ-1:0]      req_data,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy,
    output logic [15:0]             disps
);

    localparam int c_OW = $clog2(NREQ);
    localparam int c_SW = c_OW + 1;
    localparam int c_CW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_SHARE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NREQ-1:0] r_grant;
    logic [NREQ-1:0] w_grant_nxt;
    logic [c_OW-1:0] r_owner;
    logic [c_OW-1:0] w_owner_nxt;
    logic [c_OW-1:0] r_rr_ptr;
    logic [c_OW-1:0] w_rr_ptr_nxt;
    logic [c_CW-1:0] r_hold_cnt;
    logic [c_CW-1:0] w_hold_cnt_nxt;
    logic [c_CW-1:0] w_hold_inc;
    logic [15:0]     r_disps;

    logic [NREQ-1:0] w_cand;
    logic [c_OW-1:0] w_pick_idx;
    logic            w_pick_found;
    logic            w_owner_req;
    logic            w_hold_done;
    logic            w_handoff;
    logic            w_release;

    // Candidates never include the current owner. A handoff therefore always
    // moves the grant to someone else. In IDLE the grant is zero, so every
    // request is a candidate.
    assign w_cand      = req & ~r_grant;
    assign w_owner_req = |(req & r_grant);
    assign w_hold_done = (r_hold_cnt == c_CW'(HOLD_CYCLES - 1));
    assign w_hold_inc  = (r_hold_cnt == c_CW'(HOLD_CYCLES)) ? r_hold_cnt
                                                            : r_hold_cnt + c_CW'(1);

    // Round-robin search. The loop walks from farthest to nearest, so the
    // candidate closest to r_rr_ptr is the one left in w_pick_idx.
    always_comb begin : pick
        logic [c_SW-1:0] v_sum;
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        v_sum        = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            v_sum = {1'b0, r_rr_ptr} + c_SW'(k);
            if (v_sum >= c_SW'(NREQ)) begin
                v_sum = v_sum - c_SW'(NREQ);
            end
            if (w_cand[v_sum[c_OW-1:0]]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = v_sum[c_OW-1:0];
            end
        end
    end

    // Next-state and next-grant logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_owner_nxt    = r_owner;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_hold_cnt_nxt = r_hold_cnt;
        w_handoff      = 1'b0;
        w_release      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_handoff = w_pick_found;
            end
            ST_OWN: begin
                // While the hold runs, only the owner's own release can move
                // the grant.
                if (!w_owner_req) begin
                    w_handoff = w_pick_found;
                    w_release = !w_pick_found;
                end else begin
                    w_hold_cnt_nxt = w_hold_inc;
                    if (w_hold_done) begin
                        w_state_nxt = ST_SHARE;
                    end
                end
            end
            ST_SHARE: begin
                // A release and a preemption on the same edge collapse into a
                // single handoff.
                if (!w_owner_req || w_pick_found) begin
                    w_handoff = w_pick_found;
                    w_release = !w_pick_found;
                end else begin
                    w_hold_cnt_nxt = w_hold_inc;
                end
            end
            default: begin
                w_release = 1'b1;
            end
        endcase

        if (w_handoff) begin
            w_state_nxt    = ST_OWN;
            w_grant_nxt    = NREQ'(1) << w_pick_idx;
            w_owner_nxt    = w_pick_idx;
            w_hold_cnt_nxt = '0;
            w_rr_ptr_nxt   = (w_pick_idx == c_OW'(NREQ - 1)) ? '0
                                                             : w_pick_idx + c_OW'(1);
        end else if (w_release) begin
            w_state_nxt    = ST_IDLE;
            w_grant_nxt    = '0;
            w_owner_nxt    = '0;
            w_hold_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end

    // The display word follows the owner that is registered now. It therefore
    // lags grant by one cycle, and data from a non-owner can never appear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_disps <= IDLE_VALUE;
        end else if (r_state != ST_IDLE) begin
            r_disps <= req_data[{r_owner, 4'b0000} +: 16];
        end
`ifdef HOLD_LAST_EN
        else begin
            r_disps <= r_disps;
        end
`else
        else begin
            r_disps <= IDLE_VALUE;
        end
`endif
    end

    assign grant = r_grant;
    assign owner = r_owner;
    assign busy  = |r_grant;
    assign disps = r_disps;

endmodule
`default_nettype wire

// File: tb/tb_display_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_share_arbiter
//  Description : Self-checking bench for display_share_arbiter with NREQ=4,
//                HOLD_CYCLES=4 and IDLE_VALUE=0. It runs three parts:
//                  - a table of directed vectors
//                  - hand-written hold, round-robin and reset sequences
//                  - a random run compared against an ownership model
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_share_arbiter;

    localparam int          c_NREQ = 4;
    localparam int          c_HOLD = 4;
    localparam logic [15:0] c_IDLE = 16'h0000;
`ifdef HOLD_LAST_EN
    localparam bit          c_HOLD_LAST = 1'b1;
`else
    localparam bit          c_HOLD_LAST = 1'b0;
`endif
    // disps expected once IDLE follows an owner whose word was 16'h1234
    localparam logic [15:0] c_IDLE_AFTER = c_HOLD_LAST ? 16'h1234 : c_IDLE;
    localparam logic [63:0] c_DATA = 64'h4444_1234_2222_1111;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] req_data;
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic        busy;
    logic [15:0] disps;

    int n_checks = 0;
    int n_errors = 0;

    display_share_arbiter #(
        .NREQ        (c_NREQ),
        .HOLD_CYCLES (c_HOLD),
        .IDLE_VALUE  (c_IDLE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .grant    (grant),
        .owner    (owner),
        .busy     (busy),
        .disps    (disps)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives inputs, waits one active edge, then settles before sampling.
    task automatic apply(input logic r, input logic [3:0] q);
        rst = r;
        req = q;
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // The owner holds the display for `age` edges since its grant. A requester
    // other than the owner can take over once age >= HOLD. Owner -1 means idle.
    int          m_owner;
    int          m_age;
    int          m_ptr;
    logic [15:0] m_disps;

    task automatic model_step(input logic r, input logic [3:0] q, input logic [63:0] d);
        logic [3:0] others;
        int         p;
        if (r) begin
            m_owner = -1; m_age = 0; m_ptr = 0; m_disps = c_IDLE;
            return;
        end
        if (m_owner >= 0)      m_disps = d[16*m_owner +: 16];
        else if (!c_HOLD_LAST) m_disps = c_IDLE;
        others = q;
        if (m_owner >= 0) others[m_owner] = 1'b0;
        p = -1;
        for (int k = 0; k < c_NREQ; k++) begin
            if (p < 0 && others[(m_ptr + k) % c_NREQ]) p = (m_ptr + k) % c_NREQ;
        end
        if (m_owner < 0 || !q[m_owner] || (m_age >= c_HOLD && p >= 0)) begin
            m_age = 0;
            if (p >= 0) begin
                m_owner = p;
                m_ptr   = (p + 1) % c_NREQ;
            end else begin
                m_owner = -1;
            end
        end else begin
            m_age++;
        end
    endtask

    function automatic logic [22:0] model_outs();
        logic [3:0] g;
        logic [1:0] o;
        g = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        o = (m_owner < 0) ? 2'd0 : 2'(m_owner);
        return {g, o, (m_owner >= 0), m_disps};
    endfunction

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  grant;
        logic [1:0]  owner;
        logic        busy;
        logic [15:0] disps;
    } vec_t;

    vec_t tbl[15];

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        req_data = c_DATA;

        // Directed vectors: reset, a single requester, handoff on release,
        // hold restart, and reset at the end.
        tbl[0]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 16'h0000};
        tbl[1]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 16'h0000};
        tbl[2]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 16'h1234};
        tbl[3]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 16'h1234};
        tbl[4]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, c_IDLE_AFTER};
        tbl[5]  = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, c_IDLE_AFTER};
        tbl[6]  = '{1'b0, 4'b0110, 4'b0010, 2'd1, 1'b1, 16'h2222};
        tbl[7]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 16'h2222};
        tbl[8]  = '{1'b0, 4'b1100, 4'b0100, 2'd2, 1'b1, 16'h1234};
        tbl[9]  = '{1'b0, 4'b1100, 4'b0100, 2'd2, 1'b1, 16'h1234};
        tbl[10] = '{1'b0, 4'b1100, 4'b0100, 2'd2, 1'b1, 16'h1234};
        tbl[11] = '{1'b0, 4'b1100, 4'b0100, 2'd2, 1'b1, 16'h1234};
        tbl[12] = '{1'b0, 4'b1100, 4'b1000, 2'd3, 1'b1, 16'h1234};
        tbl[13] = '{1'b0, 4'b1100, 4'b1000, 2'd3, 1'b1, 16'h4444};
        tbl[14] = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 16'h0000};

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 15; i++) begin
            apply(tbl[i].rst, tbl[i].req);
            check($sformatf("vec%0d {grant,owner,busy,disps}", i),
                  32'({grant, owner, busy, disps}),
                  32'({tbl[i].grant, tbl[i].owner, tbl[i].busy, tbl[i].disps}));
        end

        // Hold: owner 0 must keep the display for 4 edges after its grant.
        // req[3] takes over on the 5th edge.
        apply(1'b1, 4'b0000);
        apply(1'b0, 4'b0001);
        check("hold_first_grant", 32'(grant), 32'(4'b0001));
        for (int k = 1; k <= 5; k++) begin
            apply(1'b0, 4'b1001);
            check($sformatf("hold_edge%0d_grant", k), 32'(grant),
                  32'((k < 5) ? 4'b0001 : 4'b1000));
        end

        // Round-robin: all four requesters are held high. The owner moves
        // every 5 edges.
        apply(1'b1, 4'b0000);
        for (int n = 0; n <= 20; n++) begin
            apply(1'b0, 4'b1111);
            check($sformatf("rr_edge%0d_owner", n), 32'(owner), 32'((n / 5) % 4));
        end

        // Reset in the middle of a SHARE period of owner 3.
        apply(1'b1, 4'b0000);
        for (int k = 0; k < 7; k++) apply(1'b0, 4'b1000);
        apply(1'b1, 4'b1000);
        check("midrst_outputs", 32'({grant, owner, busy, disps}), 32'(23'd0));
        apply(1'b0, 4'b1000);
        check("midrst_regrant", 32'({grant, owner, busy}), 32'({4'b1000, 2'd3, 1'b1}));
        apply(1'b0, 4'b0111);
        check("midrst_handoff", 32'(grant), 32'(4'b0001));

        // Random run against the model. Requests toggle rarely, so each
        // request stays up long enough for holds and preemptions to occur.
        apply(1'b1, 4'b0000);
        model_step(1'b1, 4'b0000, req_data);
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 249) == 0);
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            end
            if ($urandom_range(0, 3) == 0) req_data = {$urandom, $urandom};
            @(posedge clk);
            model_step(rst, req, req_data);
            #1;
            check($sformatf("rand%0d {grant,owner,busy,disps}", n),
                  32'({grant, owner, busy, disps}), 32'(model_outs()));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
